bus_scheduler: RTL

BUS_SCHEDULER -- requirements
Module: bus_scheduler

---
 rtl/bus_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bus_scheduler.sv
// Three-requester round-robin bus scheduler with tenure limit and one dead cycle between owners.
// Grant appears 1 cycle after request; the owner holds the bus until it drops Breq or hits MAX_TENURE.
module bus_scheduler #(
    parameter int NUM_REQ    = 3,
    parameter int MAX_TENURE = 16
) (
    input  logic               clk,
    input  logic               bReset,
    input  logic [NUM_REQ-1:0] Breq,
    output logic [NUM_REQ-1:0] Bgnt,
    output logic [1:0]         Owner,
    output logic               BusBusy,
    output logic               Timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam logic [7:0] LP_MAX_TEN = 8'(MAX_TENURE);
    localparam logic [1:0] LP_NO_OWN  = 2'b11;

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [1:0]         r_owner;
    logic               r_busy;
    logic               r_timeout;
    logic [7:0]         r_tenure;
    logic [1:0]         r_last;

    logic [1:0]         w_cand1;
    logic [1:0]         w_cand2;
    logic [1:0]         w_winner;
    logic               w_winner_vld;
    logic               w_owner_req;
    logic               w_tenure_max;

    logic [1:0]         w_nxt_state;
    logic [NUM_REQ-1:0] w_nxt_gnt;
    logic [1:0]         w_nxt_owner;
    logic               w_nxt_timeout;
    logic [7:0]         w_nxt_tenure;
    logic [1:0]         w_nxt_last;

    // The previous owner is always the last candidate, which also demotes a timed-out owner.
    always_comb begin
        w_cand1 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_cand2 = (w_cand1 == 2'd2) ? 2'd0 : w_cand1 + 2'd1;
        w_winner_vld = |Breq;
        if (Breq[w_cand1]) begin
            w_winner = w_cand1;
        end else if (Breq[w_cand2]) begin
            w_winner = w_cand2;
        end else begin
            w_winner = r_last;
        end
    end

    assign w_owner_req  = |(Breq & r_gnt);
    assign w_tenure_max = (r_tenure == LP_MAX_TEN);

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_gnt     = r_gnt;
        w_nxt_owner   = r_owner;
        w_nxt_timeout = 1'b0;
        w_nxt_tenure  = r_tenure;
        w_nxt_last    = r_last;
        case (r_state)
            ST_IDLE, ST_RECOVER: begin
                if (w_winner_vld) begin
                    w_nxt_state  = ST_GRANT;
                    w_nxt_gnt    = NUM_REQ'(1) << w_winner;
                    w_nxt_owner  = w_winner;
                    w_nxt_tenure = 8'd1;
                    w_nxt_last   = w_winner;
                end else begin
                    w_nxt_state  = ST_IDLE;
                    w_nxt_gnt    = '0;
                    w_nxt_owner  = LP_NO_OWN;
                    w_nxt_tenure = 8'd0;
                end
            end
            ST_GRANT: begin
                // A request drop wins over the tenure limit, so no Timeout in that case.
                if (!w_owner_req || w_tenure_max) begin
                    w_nxt_state   = ST_RECOVER;
                    w_nxt_gnt     = '0;
                    w_nxt_owner   = LP_NO_OWN;
                    w_nxt_tenure  = 8'd0;
                    w_nxt_timeout = w_owner_req;
                end else if (r_tenure != 8'hFF) begin
                    w_nxt_tenure = r_tenure + 8'd1;
                end
            end
            default: begin
                w_nxt_state  = ST_IDLE;
                w_nxt_gnt    = '0;
                w_nxt_owner  = LP_NO_OWN;
                w_nxt_tenure = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (bReset) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_owner   <= LP_NO_OWN;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_tenure  <= 8'd0;
            r_last    <= 2'd2;
        end else begin
            r_state   <= w_nxt_state;
            r_gnt     <= w_nxt_gnt;
            r_owner   <= w_nxt_owner;
            r_busy    <= |w_nxt_gnt;
            r_timeout <= w_nxt_timeout;
            r_tenure  <= w_nxt_tenure;
            r_last    <= w_nxt_last;
        end
    end

    assign Bgnt    = r_gnt;
    assign Owner   = r_owner;
    assign BusBusy = r_busy;
    assign Timeout = r_timeout;

endmodule
